// File: rtl/ctrl_pipe_unit.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_unit
//
// Pipelined control unit. Decodes the instruction sitting in ID into a
// control word and carries it through EX, MEM and WB slots. Each slot holds
// a valid bit and a destination register. The unit also detects load-use
// hazards, which stall ID and insert a bubble into EX. A flush from
// branch/jump resolution kills the ID instruction. Instructions that
// reach WB are counted.
//
// Ports:
//   clk, reset                clock and synchronous active-high reset
//   id_valid                  ID slot holds a real instruction
//   id_opcode, id_funct       ID instruction fields
//   id_rs, id_rt, id_rd       ID register addresses
//   flush                     kill the instruction currently in ID
//   stall                     hold PC and IF/ID this cycle (combinational)
//   jump                      ID holds a valid JMP/JAL (combinational)
//   ex/mem/wb_ctrl            stage control words
//   ex/mem/wb_dest            stage destination registers
//   ex/mem/wb_valid           stage holds a real instruction
//   retire_count              number of instructions that reached WB
//
// Control word layout, MSB first:
//   {RegWrite, MemtoReg, MemWrite, MemRead, Branch, ALUSrc, RegDst,
//    opcode, funct}
// ---------------------------------------------------------------------------
module ctrl_pipe_unit #(
    parameter int OPCODE_W  = 4,
    parameter int FUNCT_W   = 6,
    parameter int REG_W     = 2,
    parameter int JAL_REG   = 2,
    parameter int RTYPE_MAX = 7,
    parameter int CNT_W     = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              id_valid,
    input  logic [OPCODE_W-1:0]               id_opcode,
    input  logic [FUNCT_W-1:0]                id_funct,
    input  logic [REG_W-1:0]                  id_rs,
    input  logic [REG_W-1:0]                  id_rt,
    input  logic [REG_W-1:0]                  id_rd,
    input  logic                              flush,
    output logic                              stall,
    output logic                              jump,
    output logic [7+OPCODE_W+FUNCT_W-1:0]     ex_ctrl,
    output logic [7+OPCODE_W+FUNCT_W-1:0]     mem_ctrl,
    output logic [7+OPCODE_W+FUNCT_W-1:0]     wb_ctrl,
    output logic [REG_W-1:0]                  ex_dest,
    output logic [REG_W-1:0]                  mem_dest,
    output logic [REG_W-1:0]                  wb_dest,
    output logic                              ex_valid,
    output logic                              mem_valid,
    output logic                              wb_valid,
    output logic [CNT_W-1:0]                  retire_count
);

    localparam int CW = 7 + OPCODE_W + FUNCT_W;

    // Position of MemRead in the control word.
    localparam int MEMREAD_BIT = CW - 4;

    // Flag order: RegWrite, MemtoReg, MemWrite, MemRead, Branch, ALUSrc, RegDst
    logic [6:0]       decFlags;
    logic [REG_W-1:0] decDest;
    logic             usesRs;
    logic             usesRt;
    logic             hazardRs;
    logic             hazardRt;

    // Decode of the ID instruction. Unknown opcodes produce no flags but
    // still travel down the pipe as valid instructions. uses_rs/uses_rt
    // only feed the hazard check.
    always_comb begin
        decFlags = 7'b0000000;
        usesRs   = 1'b1;
        usesRt   = 1'b0;
        case (id_opcode)
            OPCODE_W'(15): begin
                usesRt = 1'b1;
                if (id_funct <= FUNCT_W'(RTYPE_MAX)) begin
                    decFlags = 7'b1000001;
                end
            end
            OPCODE_W'(0), OPCODE_W'(1): begin
                decFlags = 7'b0000100;
                usesRt   = 1'b1;
            end
            OPCODE_W'(2), OPCODE_W'(3): decFlags = 7'b0000100;
            OPCODE_W'(4), OPCODE_W'(5): decFlags = 7'b1000010;
            OPCODE_W'(6): begin
                decFlags = 7'b1000010;
                usesRs   = 1'b0;
            end
            OPCODE_W'(7): decFlags = 7'b1101010;
            OPCODE_W'(8): begin
                decFlags = 7'b0010010;
                usesRt   = 1'b1;
            end
            OPCODE_W'(9): usesRs = 1'b0;
            OPCODE_W'(10): begin
                decFlags = 7'b1000000;
                usesRs   = 1'b0;
            end
            default: decFlags = 7'b0000000;
        endcase

        if (id_opcode == OPCODE_W'(10)) begin
            decDest = REG_W'(JAL_REG);
        end else if (decFlags[0]) begin
            decDest = id_rd;
        end else begin
            decDest = id_rt;
        end
    end

    // A load in EX delivers its data too late for an ID consumer, so that
    // consumer waits one cycle. A flush overrides the stall: the
    // instruction is dead anyway.
    always_comb begin
        hazardRs = usesRs && (id_rs == ex_dest);
        hazardRt = usesRt && (id_rt == ex_dest);
        stall    = id_valid && ex_valid && ex_ctrl[MEMREAD_BIT]
                   && (hazardRs || hazardRt) && !flush;
        jump     = id_valid && ((id_opcode == OPCODE_W'(9)) ||
                                (id_opcode == OPCODE_W'(10)));
    end

    // Stage advance. MEM and WB always shift. EX takes the decoded ID
    // instruction unless it is flushed, stalled or empty. In those cases
    // EX takes a zero bubble. The retire counter looks at the WB
    // occupancy before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl      <= '0;
            mem_ctrl     <= '0;
            wb_ctrl      <= '0;
            ex_dest      <= '0;
            mem_dest     <= '0;
            wb_dest      <= '0;
            ex_valid     <= 1'b0;
            mem_valid    <= 1'b0;
            wb_valid     <= 1'b0;
            retire_count <= '0;
        end else begin
            mem_ctrl  <= ex_ctrl;
            mem_dest  <= ex_dest;
            mem_valid <= ex_valid;
            wb_ctrl   <= mem_ctrl;
            wb_dest   <= mem_dest;
            wb_valid  <= mem_valid;

            if (flush || stall || !id_valid) begin
                ex_ctrl  <= '0;
                ex_dest  <= '0;
                ex_valid <= 1'b0;
            end else begin
                ex_ctrl  <= {decFlags, id_opcode, id_funct};
                ex_dest  <= decDest;
                ex_valid <= 1'b1;
            end

            if (wb_valid) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_unit
//
// Self-checking bench for ctrl_pipe_unit. The DUT uses a 4-bit retire
// counter so that wrap-around can be exercised. A behavioural model tracks
// the instructions in each stage as plain records. Every cycle it is
// compared against the DUT. Hand-computed literal expectations pin the
// model to known answers.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_unit;

    localparam int OPCODE_W = 4;
    localparam int FUNCT_W  = 6;
    localparam int REG_W    = 2;
    localparam int CNT_W    = 4;
    localparam int CW       = 7 + OPCODE_W + FUNCT_W;

    logic                clk = 1'b0;
    logic                reset;
    logic                idValid;
    logic [OPCODE_W-1:0] idOpcode;
    logic [FUNCT_W-1:0]  idFunct;
    logic [REG_W-1:0]    idRs;
    logic [REG_W-1:0]    idRt;
    logic [REG_W-1:0]    idRd;
    logic                flush;
    logic                stall;
    logic                jump;
    logic [CW-1:0]       exCtrl;
    logic [CW-1:0]       memCtrl;
    logic [CW-1:0]       wbCtrl;
    logic [REG_W-1:0]    exDest;
    logic [REG_W-1:0]    memDest;
    logic [REG_W-1:0]    wbDest;
    logic                exValid;
    logic                memValid;
    logic                wbValid;
    logic [CNT_W-1:0]    retireCount;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W),
        .REG_W    (REG_W),
        .JAL_REG  (2),
        .RTYPE_MAX(7),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (idValid),
        .id_opcode   (idOpcode),
        .id_funct    (idFunct),
        .id_rs       (idRs),
        .id_rt       (idRt),
        .id_rd       (idRd),
        .flush       (flush),
        .stall       (stall),
        .jump        (jump),
        .ex_ctrl     (exCtrl),
        .mem_ctrl    (memCtrl),
        .wb_ctrl     (wbCtrl),
        .ex_dest     (exDest),
        .mem_dest    (memDest),
        .wb_dest     (wbDest),
        .ex_valid    (exValid),
        .mem_valid   (memValid),
        .wb_valid    (wbValid),
        .retire_count(retireCount)
    );

    int total = 0;
    int bad   = 0;

    // Model state. Index 0 is EX, 1 is MEM, 2 is WB.
    logic             mValid [3];
    logic [CW-1:0]    mCtrl  [3];
    logic [REG_W-1:0] mDest  [3];
    logic [CNT_W-1:0] mCount;
    bit               modelLive = 1'b0;

    int               cyc = 0;
    int               stallSeen = 0;
    logic             lastJump;
    logic             lastExpStall;
    logic [CNT_W-1:0] prevCount = '0;
    bit               sawWrap = 1'b0;

    // Report one comparison.
    task automatic checkValue(input string name, input logic [31:0] got,
                              input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Return the flags for an opcode, in the order
    // RegWrite MemtoReg MemWrite MemRead Branch ALUSrc RegDst.
    function automatic logic [6:0] flagsFor(input int op, input int f);
        if (op == 15) return (f <= 7) ? 7'b1000001 : 7'b0000000;
        if (op <= 3)  return 7'b0000100;
        if (op <= 6)  return 7'b1000010;
        if (op == 7)  return 7'b1101010;
        if (op == 8)  return 7'b0010010;
        if (op == 10) return 7'b1000000;
        return 7'b0000000;
    endfunction

    // Predict a load-use stall. The model recognises a load in EX by its
    // opcode field, not by its MemRead flag.
    function automatic logic modelStall();
        int  op;
        int  exOp;
        bit  readsRs;
        bit  readsRt;
        op      = int'(idOpcode);
        exOp    = int'(mCtrl[0][FUNCT_W +: OPCODE_W]);
        readsRs = !(op == 6 || op == 9 || op == 10);
        readsRt = (op == 15 || op == 0 || op == 1 || op == 8);
        return idValid && mValid[0] && (exOp == 7) && !flush &&
               ((readsRs && idRs == mDest[0]) || (readsRt && idRt == mDest[0]));
    endfunction

    // Advance the model by one clock edge.
    task automatic updateModel(input logic expStall);
        int         op;
        logic [6:0] fl;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                mValid[i] = 1'b0;
                mCtrl[i]  = '0;
                mDest[i]  = '0;
            end
            mCount    = '0;
            modelLive = 1'b1;
        end else if (modelLive) begin
            if (mValid[2]) mCount = mCount + 1'b1;
            for (int i = 2; i > 0; i--) begin
                mValid[i] = mValid[i-1];
                mCtrl[i]  = mCtrl[i-1];
                mDest[i]  = mDest[i-1];
            end
            if (flush || expStall || !idValid) begin
                mValid[0] = 1'b0;
                mCtrl[0]  = '0;
                mDest[0]  = '0;
            end else begin
                op        = int'(idOpcode);
                fl        = flagsFor(op, int'(idFunct));
                mValid[0] = 1'b1;
                mCtrl[0]  = {fl, idOpcode, idFunct};
                mDest[0]  = (op == 10) ? REG_W'(2) : (fl[0] ? idRd : idRt);
            end
        end
    endtask

    // Compare every registered output with the model. This runs once per
    // cycle, away from the clock edge.
    task automatic checkOutput();
        if (modelLive) begin
            checkValue("exValid",  32'(exValid),  32'(mValid[0]));
            checkValue("memValid", 32'(memValid), 32'(mValid[1]));
            checkValue("wbValid",  32'(wbValid),  32'(mValid[2]));
            checkValue("exCtrl",   32'(exCtrl),   32'(mCtrl[0]));
            checkValue("memCtrl",  32'(memCtrl),  32'(mCtrl[1]));
            checkValue("wbCtrl",   32'(wbCtrl),   32'(mCtrl[2]));
            checkValue("exDest",   32'(exDest),   32'(mDest[0]));
            checkValue("memDest",  32'(memDest),  32'(mDest[1]));
            checkValue("wbDest",   32'(wbDest),   32'(mDest[2]));
            checkValue("retireCount", 32'(retireCount), 32'(mCount));
            if (prevCount == 4'd15 && retireCount == 4'd0) sawWrap = 1'b1;
            prevCount = retireCount;
        end
    endtask

    // Drive one cycle of inputs. The task checks the combinational
    // outputs, clocks, updates the model, and checks the registered
    // outputs.
    task automatic applyStimulus(input logic v, input int op, input int f,
                                 input int rs, input int rt, input int rd,
                                 input logic fl);
        logic expStall;
        logic expJump;
        idValid  = v;
        idOpcode = OPCODE_W'(op);
        idFunct  = FUNCT_W'(f);
        idRs     = REG_W'(rs);
        idRt     = REG_W'(rt);
        idRd     = REG_W'(rd);
        flush    = fl;
        #1;
        expStall = modelStall();
        expJump  = v && (op == 9 || op == 10);
        if (modelLive) begin
            checkValue("stall", 32'(stall), 32'(expStall));
            checkValue("jump",  32'(jump),  32'(expJump));
        end
        if (stall === 1'b1) stallSeen++;
        lastJump     = jump;
        lastExpStall = expStall;
        @(posedge clk);
        cyc++;
        updateModel(expStall);
        @(negedge clk);
        checkOutput();
    endtask

    // Issue a valid instruction. While the model predicts a stall, the
    // same instruction is presented again, as IF/ID would hold it. The
    // number of repeats is bounded.
    task automatic issue(input int op, input int f, input int rs, input int rt,
                         input int rd, input logic fl);
        int tries;
        tries = 0;
        applyStimulus(1'b1, op, f, rs, rt, rd, fl);
        while (lastExpStall && tries < 3) begin
            applyStimulus(1'b1, op, f, rs, rt, rd, fl);
            tries++;
        end
        if (lastExpStall) begin
            total++;
            bad++;
            $display("[TB] FAIL stallBound: got stall after %0d repeats, want release", tries);
        end
    endtask

    // Present an empty ID slot for n cycles.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    // Hold reset for n cycles.
    task automatic doReset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    // Directed sequence of instructions with literal expectations.
    initial begin
        logic [CW-1:0] addWord;
        int            cycLoad;
        addWord = 17'b1000001_1111_000000;
        reset   = 1'b0;

        @(negedge clk);
        doReset(2);
        checkValue("resetExCtrl", 32'(exCtrl), 32'd0);
        checkValue("resetWbValid", 32'(wbValid), 32'd0);
        checkValue("resetCount", 32'(retireCount), 32'd0);

        // R-type ADD with rd=3: one cycle to EX, and WB two cycles later.
        issue(15, 0, 0, 1, 3, 1'b0);
        checkValue("addExCtrl", 32'(exCtrl), 32'(addWord));
        checkValue("addExDest", 32'(exDest), 32'd3);
        idle(2);
        checkValue("addWbValid", 32'(wbValid), 32'd1);
        checkValue("addWbDest", 32'(wbDest), 32'd3);
        idle(1);
        checkValue("addRetired", 32'(retireCount), 32'd1);

        // Load-use on rs: one stall cycle. ADD enters EX 2 cycles after LWD.
        stallSeen = 0;
        issue(7, 0, 0, 1, 0, 1'b0);
        cycLoad = cyc;
        issue(15, 0, 1, 2, 3, 1'b0);
        checkValue("luStallCycles", 32'(stallSeen), 32'd1);
        checkValue("luAddDelay", 32'(cyc - cycLoad), 32'd2);
        checkValue("luAddInEx", 32'(exCtrl), 32'(addWord));
        idle(4);
        checkValue("luRetired", 32'(retireCount), 32'd3);

        // LHI does not read rs, so it does not stall.
        stallSeen = 0;
        issue(7, 0, 0, 1, 0, 1'b0);
        issue(6, 0, 1, 1, 0, 1'b0);
        checkValue("lhiNoStall", 32'(stallSeen), 32'd0);
        checkValue("lhiFlags", 32'(exCtrl[CW-1 -: 7]), 32'b1000010);
        idle(4);

        // A hazard and a flush in the same cycle give a bubble and no stall.
        stallSeen = 0;
        issue(7, 0, 0, 1, 0, 1'b0);
        applyStimulus(1'b1, 15, 0, 1, 0, 3, 1'b1);
        checkValue("flushNoStall", 32'(stallSeen), 32'd0);
        checkValue("flushBubble", 32'(exValid), 32'd0);
        idle(4);
        checkValue("flushRetired", 32'(retireCount), 32'd6);

        // JAL raises jump in the same cycle and links to register 2.
        applyStimulus(1'b1, 10, 0, 0, 0, 0, 1'b0);
        checkValue("jalJump", 32'(lastJump), 32'd1);
        checkValue("jalDest", 32'(exDest), 32'd2);
        checkValue("jalRegWrite", 32'(exCtrl[CW-1]), 32'd1);

        // A mix of instructions. The model checks these.
        // Load-use on rt through SWD, branches, an R-type funct above 7, and JMP.
        issue(8, 0, 1, 2, 0, 1'b0);
        issue(1, 0, 3, 0, 0, 1'b0);
        issue(15, 9, 0, 1, 2, 1'b0);
        issue(3, 0, 2, 0, 0, 1'b0);
        issue(5, 0, 1, 3, 0, 1'b0);
        issue(7, 0, 0, 2, 0, 1'b0);
        issue(8, 0, 0, 2, 0, 1'b0);
        issue(9, 0, 0, 0, 0, 1'b0);
        idle(4);

        // Retire counter wrap: 17 NOPs after reset, ending at 1.
        doReset(1);
        sawWrap = 1'b0;
        for (int i = 0; i < 17; i++) issue(11, 0, 0, 0, 0, 1'b0);
        idle(3);
        checkValue("wrapCount", 32'(retireCount), 32'd1);
        checkValue("wrapSeen", 32'(sawWrap), 32'd1);

        // Reset in the middle of a stream discards the in-flight work.
        for (int i = 0; i < 3; i++) issue(11, 0, 0, 0, 0, 1'b0);
        doReset(1);
        checkValue("midResetEx", 32'(exValid), 32'd0);
        checkValue("midResetMem", 32'(memValid), 32'd0);
        checkValue("midResetWb", 32'(wbValid), 32'd0);
        checkValue("midResetCount", 32'(retireCount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
